// File: rtl/beam_mac_sched_if.sv
// Bus bundle between the beam-MAC scheduler and its controller: symbol/data
// handshake in, MAC issue strobes, codeword bank selects and output strobes out.
interface beam_mac_sched_if #(
    parameter int RE_W = 9
);
    logic            i_sym_start;
    logic            i_data_vld;
    logic            i_cwd_commit;
    logic            o_busy;
    logic            o_mac_vld;
    logic [RE_W-1:0] o_re_idx;
    logic            o_cwd_bank;
    logic            o_cwd_wr_bank;
    logic            o_out_vld;
    logic            o_out_sop;
    logic            o_out_eop;
    logic [RE_W-1:0] o_out_re_idx;
    logic [3:0]      o_sym_idx;
    logic            o_done;
    logic            o_err_overrun;

    modport master (
        output i_sym_start, i_data_vld, i_cwd_commit,
        input  o_busy, o_mac_vld, o_re_idx, o_cwd_bank, o_cwd_wr_bank,
               o_out_vld, o_out_sop, o_out_eop, o_out_re_idx,
               o_sym_idx, o_done, o_err_overrun
    );

    modport slave (
        input  i_sym_start, i_data_vld, i_cwd_commit,
        output o_busy, o_mac_vld, o_re_idx, o_cwd_bank, o_cwd_wr_bank,
               o_out_vld, o_out_sop, o_out_eop, o_out_re_idx,
               o_sym_idx, o_done, o_err_overrun
    );
endinterface

// File: rtl/beam_mac_sched.sv
// Per-symbol beam-MAC scheduler: walks the RE index through the antenna buffer,
// tracks MAC latency for output capture, and double-buffers the codeword bank.
module beam_mac_sched #(
    parameter int NUM_RE  = 480,
    parameter int NUM_SYM = 14,
    parameter int MAC_LAT = 4
) (
    input logic             i_clk,
    input logic             i_rst_n,
    beam_mac_sched_if.slave bus
);
    localparam int RE_W = $clog2(NUM_RE);
    localparam logic [RE_W-1:0] LAST_RE  = RE_W'(NUM_RE - 1);
    localparam logic [3:0]      LAST_SYM = 4'(NUM_SYM - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t            state_q, state_d;
    logic [RE_W-1:0]   count_q, count_d;
    logic [RE_W-1:0]   re_idx_q, re_idx_d;
    logic              mac_vld_q, mac_vld_d;
    logic              pending_q, pending_d;
    logic              bank_q, bank_d;
    logic              overrun_q, overrun_d;
    logic [3:0]        sym_q, sym_d;
    logic [MAC_LAT-1:0] vld_pipe_q, vld_pipe_d;
    logic [MAC_LAT-1:0] sop_pipe_q, sop_pipe_d;
    logic [MAC_LAT-1:0] eop_pipe_q, eop_pipe_d;
    logic [RE_W-1:0]   idx_pipe_q [MAC_LAT];
    logic [RE_W-1:0]   idx_pipe_d [MAC_LAT];
    logic              start_ok;
    logic              out_eop;

    assign out_eop = eop_pipe_q[MAC_LAT-1];

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        re_idx_d  = re_idx_q;
        mac_vld_d = 1'b0;
        pending_d = pending_q | bus.i_cwd_commit;
        bank_d    = bank_q;
        overrun_d = 1'b0;
        sym_d     = sym_q;
        start_ok  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.i_sym_start) begin
                    state_d  = RUN;
                    count_d  = '0;
                    start_ok = 1'b1;
                end
            end
            RUN: begin
                overrun_d = bus.i_sym_start;
                if (bus.i_data_vld) begin
                    mac_vld_d = 1'b1;
                    re_idx_d  = count_q;
                    count_d   = count_q + 1'b1;
                    if (count_q == LAST_RE) state_d = DRAIN;
                end
            end
            DRAIN: begin
                overrun_d = bus.i_sym_start;
                if (out_eop) begin
                    state_d = IDLE;
                    sym_d   = (sym_q == LAST_SYM) ? 4'd0 : sym_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // A swap only lands on an accepted start, so a symbol never mixes banks.
        if (start_ok && pending_d) begin
            bank_d    = ~bank_q;
            pending_d = 1'b0;
        end
    end

    always_comb begin
        vld_pipe_d    = vld_pipe_q;
        sop_pipe_d    = sop_pipe_q;
        eop_pipe_d    = eop_pipe_q;
        idx_pipe_d    = idx_pipe_q;
        vld_pipe_d[0] = mac_vld_q;
        sop_pipe_d[0] = mac_vld_q & (re_idx_q == '0);
        eop_pipe_d[0] = mac_vld_q & (re_idx_q == LAST_RE);
        idx_pipe_d[0] = re_idx_q;
        for (int i = 1; i < MAC_LAT; i++) begin
            vld_pipe_d[i] = vld_pipe_q[i-1];
            sop_pipe_d[i] = sop_pipe_q[i-1];
            eop_pipe_d[i] = eop_pipe_q[i-1];
            idx_pipe_d[i] = idx_pipe_q[i-1];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            count_q    <= '0;
            re_idx_q   <= '0;
            mac_vld_q  <= 1'b0;
            pending_q  <= 1'b0;
            bank_q     <= 1'b0;
            overrun_q  <= 1'b0;
            sym_q      <= '0;
            vld_pipe_q <= '0;
            sop_pipe_q <= '0;
            eop_pipe_q <= '0;
            for (int i = 0; i < MAC_LAT; i++) idx_pipe_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            re_idx_q   <= re_idx_d;
            mac_vld_q  <= mac_vld_d;
            pending_q  <= pending_d;
            bank_q     <= bank_d;
            overrun_q  <= overrun_d;
            sym_q      <= sym_d;
            vld_pipe_q <= vld_pipe_d;
            sop_pipe_q <= sop_pipe_d;
            eop_pipe_q <= eop_pipe_d;
            idx_pipe_q <= idx_pipe_d;
        end
    end

    assign bus.o_busy        = (state_q != IDLE);
    assign bus.o_mac_vld     = mac_vld_q;
    assign bus.o_re_idx      = re_idx_q;
    assign bus.o_cwd_bank    = bank_q;
    assign bus.o_cwd_wr_bank = ~bank_q;
    assign bus.o_out_vld     = vld_pipe_q[MAC_LAT-1];
    assign bus.o_out_sop     = sop_pipe_q[MAC_LAT-1];
    assign bus.o_out_eop     = out_eop;
    assign bus.o_out_re_idx  = idx_pipe_q[MAC_LAT-1];
    assign bus.o_sym_idx     = sym_q;
    assign bus.o_done        = vld_pipe_q[MAC_LAT-1] & out_eop;
    assign bus.o_err_overrun = overrun_q;
endmodule

// File: doc/beam_mac_sched.md
BEAM_MAC_SCHED -- requirements
Module: beam_mac_sched

Interface
REQ-001 SHALL have parameter NUM_RE, default 480: resource elements (subcarriers) per symbol.
REQ-002 SHALL have parameter NUM_SYM, default 14: symbols per slot; symbol index wraps at this value.
REQ-003 SHALL have parameter MAC_LAT, default 4: beam-MAC pipeline latency in cycles, o_mac_vld to result; legal range 1..16.
REQ-004 SHALL derive localparam RE_W = $clog2(NUM_RE): RE index width.
REQ-005 SHALL use one clock; reset is asynchronous and active-low: ports i_clk and i_rst_n.
REQ-006 i_clk  input  1  rising-edge clock.
REQ-007 i_rst_n  input  1  asynchronous active-low reset.
REQ-008 i_sym_start  input  1  one-cycle pulse; requests processing of one symbol.
REQ-009 i_data_vld  input  1  antenna data for the current RE is available; low = stall.
REQ-010 i_cwd_commit  input  1  one-cycle pulse; request codeword bank swap at the next symbol start.
REQ-011 o_busy  output  1  high in RUN or DRAIN.
REQ-012 o_mac_vld  output  1  rvalid to the beam MAC array.
REQ-013 o_re_idx  output  RE_W  antenna buffer read index, qualified by o_mac_vld.
REQ-014 o_cwd_bank  output  1  active codeword bank select.
REQ-015 o_cwd_wr_bank  output  1  shadow bank for codeword writes; always ~o_cwd_bank.
REQ-016 o_out_vld, o_out_sop, o_out_eop  output  1 each  beam-sum capture strobe, first RE, last RE.
REQ-017 o_out_re_idx  output  RE_W  RE index aligned with o_out_vld.
REQ-018 o_sym_idx  output  4  current symbol index, 0..NUM_SYM-1.
REQ-019 o_done  output  1  one-cycle pulse, equal to o_out_vld & o_out_eop.
REQ-020 o_err_overrun  output  1  one-cycle pulse when i_sym_start is rejected.

Function
REQ-021 FSM states SHALL be IDLE, RUN and DRAIN.
- IDLE -> RUN on i_sym_start.
- RUN -> DRAIN on the edge issuing RE NUM_RE-1.
- DRAIN -> IDLE on the edge ending the cycle in which o_out_eop=1.
REQ-022 In RUN, at each edge with i_data_vld=1, the block SHALL register o_mac_vld=1 and o_re_idx=count, then increment count; with i_data_vld=0 it SHALL register o_mac_vld=0 and hold count.
REQ-023 The first o_mac_vld SHALL appear one cycle after the first i_data_vld=1 cycle in RUN; o_re_idx SHALL issue 0..NUM_RE-1 in order with no gaps or repeats, regardless of stalls.
REQ-024 o_out_vld, o_out_sop, o_out_eop and o_out_re_idx SHALL equal o_mac_vld, (o_mac_vld & re_idx==0), (o_mac_vld & re_idx==NUM_RE-1) and o_re_idx, each delayed exactly MAC_LAT cycles.
REQ-025 The count SHALL clear to 0 on entering RUN; i_data_vld SHALL be ignored in IDLE and DRAIN.
REQ-026 i_sym_start in RUN or DRAIN SHALL be ignored, SHALL pulse o_err_overrun for one cycle, and SHALL leave state unchanged.
REQ-027 i_cwd_commit SHALL set a pending flag; repeated commits while pending SHALL have no additional effect.
REQ-028 On the edge accepting i_sym_start with pending set, o_cwd_bank SHALL toggle and pending SHALL clear, so the whole symbol uses one bank.
REQ-029 If i_cwd_commit and an accepted i_sym_start coincide, the swap SHALL occur on that edge.
REQ-030 o_cwd_bank SHALL never change in RUN or DRAIN.
REQ-031 o_sym_idx SHALL increment on the DRAIN -> IDLE edge and wrap from NUM_SYM-1 to 0.

Reset
REQ-032 On i_rst_n=0 the block SHALL force IDLE, count=0 and pending=0 at once, and SHALL clear the delay line.
REQ-033 On i_rst_n=0 all outputs SHALL go to 0: o_busy, o_mac_vld, o_re_idx, o_cwd_bank, o_out_*, o_sym_idx, o_done and o_err_overrun; o_cwd_wr_bank SHALL be 1.
REQ-034 Reset asserted mid-symbol SHALL abandon the symbol with no o_done; the first i_sym_start after release SHALL restart at RE 0.

Verification
REQ-035 Continuous case: i_data_vld=1 throughout, one i_sym_start.
- Required: 480 consecutive o_mac_vld with idx 0..479.
- Required: o_out_sop 4 cycles after the first o_mac_vld; o_done once; o_sym_idx 0->1; o_busy low after.
REQ-036 Stall case: i_data_vld low for 3 cycles after RE 99.
- Required: o_re_idx resumes at 100 with a 3-cycle o_mac_vld gap.
- Required: o_out_vld shows the same gap shifted by 4 cycles; total 480 strobes.
REQ-037 Bank swap case: i_cwd_commit during RUN of symbol 0.
- Required: o_cwd_bank stays 0 until the next accepted i_sym_start, then 1; o_cwd_wr_bank = 0.
- Required: a second commit in the same cycle as the next start toggles the bank back to 0.
REQ-038 Overrun case: i_sym_start at RE 200 and again in DRAIN.
- Required: two o_err_overrun pulses; RE sequence and o_done unaffected.
REQ-039 Reset case: i_rst_n low at RE 100.
- Required: all outputs 0 and o_cwd_wr_bank 1; no o_done.
- Required: a new start issues RE 0 with the bank unchanged from reset (0).
REQ-040 Wrap case: 14 back-to-back symbols.
- Required: o_sym_idx goes 0..13 then 0; 14 o_done pulses.
